// File: rtl/pbs_pkg.sv
// Shared types and constants for the battle turn controller.
// Used by battle_turn_ctrl and battle_lfsr.
package pbs_pkg;

    localparam int HP_W = 8;

    // Feedback taps b7, b5, b4, b3 of the 8-bit Fibonacci LFSR.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Move codes presented to the external move table.
    localparam logic [1:0] MV_STRIKE = 2'b00;
    localparam logic [1:0] MV_JAB    = 2'b01;
    localparam logic [1:0] MV_SLAM   = 2'b10;
    localparam logic [1:0] MV_BLAST  = 2'b11;

    // Winner encodings.
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        A1_FETCH = 3'd2,
        A1_APPLY = 3'd3,
        A2_FETCH = 3'd4,
        A2_APPLY = 3'd5,
        DONE     = 3'd6
    } state_t;

    // HP after taking damage; clamps at zero instead of wrapping.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                                input logic [HP_W-1:0] dmg);
        return (hp > dmg) ? (hp - dmg) : '0;
    endfunction

endpackage

// File: rtl/battle_lfsr.sv
// 8-bit Fibonacci LFSR that shifts left every clock out of reset.
// Only the low nibble (the accuracy roll) leaves the block.
module battle_lfsr
    import pbs_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] roll
);

    // An all-zero state would lock the register, so a zero seed becomes 1.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

    logic [7:0] lfsr;

    assign roll = lfsr[3:0];

    // Shift left, feeding the XOR of the tapped bits into bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/battle_turn_ctrl.sv
// Two-player battle sequencer: collects one move per player per turn,
// time-shares the external move table, rolls accuracy and applies
// saturating damage until one player's HP reaches zero.
// Optional critical hits are enabled with the BATTLE_CRIT_EN macro.
//
// Handshake: a move is taken on a clock edge where pN_valid and pN_ready
// are both high; pN_ready is high only in COLLECT while player N has no
// move latched this turn, and drops the cycle after the capture.
module battle_turn_ctrl
    import pbs_pkg::*;
#(
    parameter logic [HP_W-1:0] HP_INIT   = 8'd50,
    parameter logic [7:0]      LFSR_SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      p1_move,
    input  logic            p1_valid,
    output logic            p1_ready,
    input  logic [1:0]      p2_move,
    input  logic            p2_valid,
    output logic            p2_ready,
    output logic [1:0]      mv_sel,
    input  logic [3:0]      mv_dmg,
    input  logic [3:0]      mv_accu,
    output logic [HP_W-1:0] p1_hp,
    output logic [HP_W-1:0] p2_hp,
    output logic            hit,
    output logic            attacker,
    output logic            busy,
    output logic            done,
    output logic [1:0]      winner,
`ifdef BATTLE_CRIT_EN
    output logic            crit,
`endif
    output state_t          dbg_state
);

    state_t          state;
    logic [1:0]      p1_lat;
    logic [1:0]      p2_lat;
    logic [3:0]      dmg_r;
    logic [3:0]      accu_r;
    logic [3:0]      roll;

    logic            cap1;
    logic            cap2;
    logic            both_held;
    logic [1:0]      p1_next;
    logic            hit_now;
    logic            crit_now;
    logic [HP_W-1:0] dmg_eff;
    logic [HP_W-1:0] tgt_hp;
    logic [HP_W-1:0] hp_after;

    assign dbg_state = state;

    battle_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (reset),
        .roll (roll)
    );

    // Handshake captures; ready is only ever high in COLLECT.
    always_comb begin
        cap1      = p1_valid & p1_ready;
        cap2      = p2_valid & p2_ready;
        p1_next   = cap1 ? p1_move : p1_lat;
        both_held = (cap1 | ~p1_ready) & (cap2 | ~p2_ready);
    end

    // Hit decision and post-attack HP of whichever player is the target.
    always_comb begin
        hit_now  = (roll <= accu_r);
        crit_now = 1'b0;
`ifdef BATTLE_CRIT_EN
        crit_now = hit_now && (roll == 4'h0);
`endif
        dmg_eff  = crit_now ? {3'b000, dmg_r, 1'b0} : {4'b0000, dmg_r};
        tgt_hp   = (state == A2_APPLY) ? p1_hp : p2_hp;
        hp_after = hit_now ? sat_sub(tgt_hp, dmg_eff) : tgt_hp;
    end

    // Turn sequencer with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            p1_hp    <= '0;
            p2_hp    <= '0;
            winner   <= WIN_NONE;
            hit      <= 1'b0;
            attacker <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            p1_ready <= 1'b0;
            p2_ready <= 1'b0;
            mv_sel   <= MV_STRIKE;
            p1_lat   <= MV_STRIKE;
            p2_lat   <= MV_STRIKE;
            dmg_r    <= '0;
            accu_r   <= '0;
`ifdef BATTLE_CRIT_EN
            crit     <= 1'b0;
`endif
        end else begin
            hit <= 1'b0;
`ifdef BATTLE_CRIT_EN
            crit <= 1'b0;
`endif
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        p1_hp    <= HP_INIT;
                        p2_hp    <= HP_INIT;
                        winner   <= WIN_NONE;
                        p1_ready <= 1'b1;
                        p2_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (cap1) begin
                        p1_lat   <= p1_move;
                        p1_ready <= 1'b0;
                    end
                    if (cap2) begin
                        p2_lat   <= p2_move;
                        p2_ready <= 1'b0;
                    end
                    if (both_held) begin
                        mv_sel   <= p1_next;
                        attacker <= 1'b0;
                        state    <= A1_FETCH;
                    end
                end
                A1_FETCH, A2_FETCH: begin
                    dmg_r  <= mv_dmg;
                    accu_r <= mv_accu;
                    mv_sel <= MV_STRIKE;
                    state  <= (state == A1_FETCH) ? A1_APPLY : A2_APPLY;
                end
                A1_APPLY: begin
                    p2_hp <= hp_after;
                    hit   <= hit_now;
`ifdef BATTLE_CRIT_EN
                    crit  <= crit_now;
`endif
                    if (hp_after == '0) begin
                        winner <= WIN_P1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        mv_sel   <= p2_lat;
                        attacker <= 1'b1;
                        state    <= A2_FETCH;
                    end
                end
                A2_APPLY: begin
                    p1_hp <= hp_after;
                    hit   <= hit_now;
`ifdef BATTLE_CRIT_EN
                    crit  <= crit_now;
`endif
                    if (hp_after == '0) begin
                        winner <= WIN_P2;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        p1_ready <= 1'b1;
                        p2_ready <= 1'b1;
                        state    <= COLLECT;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Directed bench for battle_turn_ctrl with a behavioural move table and
// an LFSR reference used to predict each accuracy roll.
module tb_battle_turn_ctrl;
    import pbs_pkg::*;

    localparam logic [7:0] HP0  = 8'd50;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] p1_move;
    logic       p1_valid;
    logic       p1_ready;
    logic [1:0] p2_move;
    logic       p2_valid;
    logic       p2_ready;
    logic [1:0] mv_sel;
    logic [3:0] mv_dmg;
    logic [3:0] mv_accu;
    logic [7:0] p1_hp;
    logic [7:0] p2_hp;
    logic       hit;
    logic       attacker;
    logic       busy;
    logic       done;
    logic [1:0] winner;
`ifdef BATTLE_CRIT_EN
    logic       crit;
`endif
    state_t     dut_state;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] m_lfsr;
    logic [7:0] exp_p1;
    logic [7:0] exp_p2;
    logic [7:0] exp_q[$];
    logic       ended;

    battle_turn_ctrl #(
        .HP_INIT   (HP0),
        .LFSR_SEED (SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .p1_move   (p1_move),
        .p1_valid  (p1_valid),
        .p1_ready  (p1_ready),
        .p2_move   (p2_move),
        .p2_valid  (p2_valid),
        .p2_ready  (p2_ready),
        .mv_sel    (mv_sel),
        .mv_dmg    (mv_dmg),
        .mv_accu   (mv_accu),
        .p1_hp     (p1_hp),
        .p2_hp     (p2_hp),
        .hit       (hit),
        .attacker  (attacker),
        .busy      (busy),
        .done      (done),
        .winner    (winner),
`ifdef BATTLE_CRIT_EN
        .crit      (crit),
`endif
        .dbg_state (dut_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- move table and reference models ----------------
    function automatic logic [3:0] tb_dmg(input logic [1:0] m);
        case (m)
            2'b00:   return 4'd3;
            2'b01:   return 4'd5;
            2'b10:   return 4'd7;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [3:0] tb_accu(input logic [1:0] m);
        case (m)
            2'b00:   return 4'd15;
            2'b01:   return 4'd12;
            2'b10:   return 4'd10;
            default: return 4'd7;
        endcase
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Combinational move table driven by the DUT's selection.
    always_comb begin
        mv_dmg  = tb_dmg(mv_sel);
        mv_accu = tb_accu(mv_sel);
    end

    // Reference LFSR; at a falling edge it holds the current cycle's value.
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Pulse start from IDLE/DONE and confirm the fresh battle.
    task automatic start_battle();
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        exp_p1 = HP0;
        exp_p2 = HP0;
        check_val("start_p1_hp", p1_hp, HP0);
        check_val("start_p2_hp", p2_hp, HP0);
        check_val("start_winner", winner, WIN_NONE);
        check_val("start_state", 32'(dut_state), 32'(COLLECT));
        check_val("start_p1_ready", p1_ready, 1);
        check_val("start_p2_ready", p2_ready, 1);
        check_val("start_busy", busy, 1);
        check_val("start_done", done, 0);
    endtask

    // Called at the falling edge of an APPLY cycle; predicts and checks it.
    task automatic attack_step(input logic by_p2, input logic [1:0] mv,
                               output logic ko);
        logic [3:0] r;
        logic [3:0] dm;
        logic       h;
        logic       cr;
        logic [7:0] d;
        logic [7:0] tgt;
        logic [7:0] nxt;
        r   = m_lfsr[3:0];
        dm  = tb_dmg(mv);
        h   = (r <= tb_accu(mv));
        cr  = 1'b0;
`ifdef BATTLE_CRIT_EN
        cr  = h && (r == 4'h0);
`endif
        d   = cr ? {3'b000, dm, 1'b0} : {4'b0000, dm};
        tgt = by_p2 ? exp_p1 : exp_p2;
        nxt = h ? ((tgt > d) ? tgt - d : 8'd0) : tgt;
        exp_q.push_back(nxt);
        if (by_p2) exp_p1 = nxt;
        else       exp_p2 = nxt;
        check_val("apply_state", 32'(dut_state), by_p2 ? 32'(A2_APPLY) : 32'(A1_APPLY));
        check_val("apply_mv_sel", mv_sel, 0);
        check_val("apply_attacker", attacker, by_p2);
        @(negedge clk);
        check_val(by_p2 ? "hit_p2" : "hit_p1", hit, h);
`ifdef BATTLE_CRIT_EN
        check_val(by_p2 ? "crit_p2" : "crit_p1", crit, cr);
`endif
        if (by_p2) check_val("p1_hp_after", p1_hp, exp_q.pop_front());
        else       check_val("p2_hp_after", p2_hp, exp_q.pop_front());
        ko = (nxt == 8'd0);
    endtask

    // Runs from the falling edge of A1_FETCH to the end of the turn.
    task automatic finish_turn(input logic [1:0] m1, input logic [1:0] m2,
                               output logic over);
        logic ko;
        check_val("a1_fetch_state", 32'(dut_state), 32'(A1_FETCH));
        check_val("a1_mv_sel", mv_sel, m1);
        check_val("a1_attacker", attacker, 0);
        check_val("a1_p1_ready", p1_ready, 0);
        check_val("a1_p2_ready", p2_ready, 0);
        check_val("a1_busy", busy, 1);
        @(negedge clk);
        attack_step(1'b0, m1, ko);
        if (ko) begin
            check_val("ko1_state", 32'(dut_state), 32'(DONE));
            check_val("ko1_winner", winner, WIN_P1);
            check_val("ko1_done", done, 1);
            check_val("ko1_busy", busy, 0);
            @(negedge clk);
            check_val("ko1_no_second_hit", hit, 0);
            check_val("ko1_p1_hp_held", p1_hp, exp_p1);
            over = 1'b1;
            return;
        end
        check_val("a2_fetch_state", 32'(dut_state), 32'(A2_FETCH));
        check_val("a2_mv_sel", mv_sel, m2);
        check_val("a2_attacker", attacker, 1);
        @(negedge clk);
        attack_step(1'b1, m2, ko);
        if (ko) begin
            check_val("ko2_state", 32'(dut_state), 32'(DONE));
            check_val("ko2_winner", winner, WIN_P2);
            check_val("ko2_done", done, 1);
            over = 1'b1;
        end else begin
            check_val("turn_end_state", 32'(dut_state), 32'(COLLECT));
            check_val("turn_end_p1_ready", p1_ready, 1);
            check_val("turn_end_p2_ready", p2_ready, 1);
            check_val("turn_end_winner", winner, WIN_NONE);
            over = 1'b0;
        end
    endtask

    // Offer both moves for one cycle; returns at the falling edge of A1_FETCH.
    task automatic submit_both(input logic [1:0] m1, input logic [1:0] m2);
        p1_move  = m1;
        p2_move  = m2;
        p1_valid = 1'b1;
        p2_valid = 1'b1;
        @(negedge clk);
        p1_valid = 1'b0;
        p2_valid = 1'b0;
    endtask

    task automatic play_turn(input logic [1:0] m1, input logic [1:0] m2,
                             output logic over);
        submit_both(m1, m2);
        finish_turn(m1, m2, over);
    endtask

    // Idle in COLLECT until a capture now puts `target` on the A1_APPLY roll.
    task automatic wait_roll(input logic [3:0] target);
        logic [7:0] ahead;
        logic       found;
        int         i;
        found = 1'b0;
        for (i = 0; i < 300; i++) begin
            ahead = lfsr_step(lfsr_step(m_lfsr));
            if (ahead[3:0] == target) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) check_val("wait_roll_timeout", 32'(i), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        p1_move  = 2'b00;
        p1_valid = 1'b0;
        p2_move  = 2'b00;
        p2_valid = 1'b0;
        ended    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check_val("rst_p1_hp", p1_hp, 0);
        check_val("rst_p2_hp", p2_hp, 0);
        check_val("rst_winner", winner, WIN_NONE);
        check_val("rst_done", done, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_hit", hit, 0);
        check_val("rst_p1_ready", p1_ready, 0);
        check_val("rst_p2_ready", p2_ready, 0);
        check_val("rst_mv_sel", mv_sel, 0);
        check_val("rst_state", 32'(dut_state), 32'(IDLE));
        reset = 1'b0;

        // Valids in IDLE are ignored.
        p1_valid = 1'b1;
        @(negedge clk);
        p1_valid = 1'b0;
        check_val("idle_ignores_valid", 32'(dut_state), 32'(IDLE));
        check_val("idle_p1_ready", p1_ready, 0);

        // Staggered handshake: P2 offers from cycle 0, P1 at cycle 4.
        start_battle();
        p2_move  = 2'b01;
        p2_valid = 1'b1;
        @(negedge clk);                      // cycle 1
        check_val("hs_p2_ready_drop", p2_ready, 0);
        check_val("hs_p1_ready_hold", p1_ready, 1);
        p2_move = 2'b11;                     // must not replace the latched move
        start   = 1'b1;                      // ignored outside IDLE/DONE
        @(negedge clk);                      // cycle 2
        start = 1'b0;
        check_val("hs_state_c2", 32'(dut_state), 32'(COLLECT));
        check_val("hs_p2_ready_c2", p2_ready, 0);
        @(negedge clk);                      // cycle 3
        check_val("hs_state_c3", 32'(dut_state), 32'(COLLECT));
        @(negedge clk);                      // cycle 4
        p1_move  = 2'b10;
        p1_valid = 1'b1;
        @(negedge clk);                      // cycle 5: A1_FETCH
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        finish_turn(2'b10, 2'b01, ended);

        // Guaranteed miss (roll 12 > accuracy 7), then guaranteed hit (roll 7).
        wait_roll(4'd12);
        play_turn(2'b11, 2'b00, ended);
        wait_roll(4'd7);
        play_turn(2'b11, 2'b00, ended);

        // Roll 0 on move 00: doubled damage only with critical hits enabled.
        wait_roll(4'd0);
        play_turn(2'b00, 2'b00, ended);

        // P1 lands move 11 every turn until P2 is knocked out.
        ended = 1'b0;
        for (int t = 0; t < 10 && !ended; t++) begin
            wait_roll(4'd5);
            play_turn(2'b11, 2'b00, ended);
        end
        check_val("p1_win_done", done, 1);
        check_val("p1_win_winner", winner, WIN_P1);
        check_val("p1_win_p2_hp", p2_hp, 0);

        // Restart from DONE; P1 always misses so P2 wins by saturation.
        start_battle();
        ended = 1'b0;
        for (int t = 0; t < 40 && !ended; t++) begin
            wait_roll(4'd12);
            play_turn(2'b11, 2'b00, ended);
        end
        check_val("p2_win_done", done, 1);
        check_val("p2_win_winner", winner, WIN_P2);
        check_val("p2_win_p1_hp", p1_hp, 0);
        check_val("p2_win_p2_hp", p2_hp, HP0);
        check_val("p2_win_busy", busy, 0);

        // Reset asserted during A1_APPLY clears everything immediately.
        start_battle();
        submit_both(2'b00, 2'b00);
        @(negedge clk);
        check_val("pre_abort_state", 32'(dut_state), 32'(A1_APPLY));
        reset = 1'b1;
        #1;
        check_val("abort_p1_hp", p1_hp, 0);
        check_val("abort_p2_hp", p2_hp, 0);
        check_val("abort_state", 32'(dut_state), 32'(IDLE));
        check_val("abort_p1_ready", p1_ready, 0);
        check_val("abort_p2_ready", p2_ready, 0);
        check_val("abort_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        start_battle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
